// File: rtl/ram_mux_rr_if.sv
// ---------------------------------------------------------------------------
// ram_mux_rr_if
//
// Purpose: bundles the master-side request/response signals and the RAM-side
// signals of the ram_mux_rr arbiter into one interface.
//
// Ports / signals (per-port fields are packed, port 0 in the LSBs):
//   port_req_i     NUM_PORTS             request per master
//   port_gnt_o     NUM_PORTS             one-hot (or zero) grant
//   port_rvalid_o  NUM_PORTS             response valid per master
//   port_addr_i    NUM_PORTS*ADDR_WIDTH  byte addresses
//   port_we_i      NUM_PORTS             write enables
//   port_be_i      NUM_PORTS*IN_WIDTH/8  byte enables
//   port_wdata_i   NUM_PORTS*IN_WIDTH    write data
//   port_rdata_o   NUM_PORTS*IN_WIDTH    read data
//   ram_en_o/ram_addr_o/ram_we_o/ram_be_o/ram_wdata_o  RAM command
//   ram_rdata_i    OUT_WIDTH             RAM read data
//
// Modports: slave = the arbiter itself, master = the masters + RAM model side.
// ---------------------------------------------------------------------------
interface ram_mux_rr_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 64
) ();

  logic [NUM_PORTS-1:0]              port_req_i;
  logic [NUM_PORTS-1:0]              port_gnt_o;
  logic [NUM_PORTS-1:0]              port_rvalid_o;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]   port_addr_i;
  logic [NUM_PORTS-1:0]              port_we_i;
  logic [NUM_PORTS*IN_WIDTH/8-1:0]   port_be_i;
  logic [NUM_PORTS*IN_WIDTH-1:0]     port_wdata_i;
  logic [NUM_PORTS*IN_WIDTH-1:0]     port_rdata_o;

  logic                              ram_en_o;
  logic [ADDR_WIDTH-1:0]             ram_addr_o;
  logic                              ram_we_o;
  logic [OUT_WIDTH/8-1:0]            ram_be_o;
  logic [OUT_WIDTH-1:0]              ram_wdata_o;
  logic [OUT_WIDTH-1:0]              ram_rdata_i;

  modport slave (
    input  port_req_i, port_addr_i, port_we_i, port_be_i, port_wdata_i,
    input  ram_rdata_i,
    output port_gnt_o, port_rvalid_o, port_rdata_o,
    output ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o
  );

  modport master (
    output port_req_i, port_addr_i, port_we_i, port_be_i, port_wdata_i,
    output ram_rdata_i,
    input  port_gnt_o, port_rvalid_o, port_rdata_o,
    input  ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o
  );

endinterface

// File: rtl/ram_mux_rr.sv
// ---------------------------------------------------------------------------
// ram_mux_rr
//
// Purpose: N-port arbiter and width adapter in front of a single-ported data
// RAM. One master is granted per cycle (fixed priority or round-robin), its
// narrow access is steered onto the matching lane of the wide RAM word, and
// the response (read data or write acknowledge) returns on that master's
// rvalid RAM_LATENCY cycles after the grant.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    ram_mux_rr_if.slave: master request/response bundle + RAM command
//          and read data (see ram_mux_rr_if.sv)
//
// Parameters:
//   NUM_PORTS    2..8 masters
//   ADDR_WIDTH   byte address width
//   IN_WIDTH     master data width (8/16/32/64), <= OUT_WIDTH
//   OUT_WIDTH    RAM data width, OUT_WIDTH/IN_WIDTH a power of two
//   ARB_MODE     0 = fixed priority (port 0 highest), 1 = round-robin
//   RAM_LATENCY  1 or 2 cycles from grant to rvalid
// ---------------------------------------------------------------------------
module ram_mux_rr #(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 64,
  parameter int ARB_MODE    = 1,
  parameter int RAM_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_mux_rr_if.slave   bus
);

  localparam int IN_BYTES  = IN_WIDTH / 8;
  localparam int OUT_BYTES = OUT_WIDTH / 8;
  localparam int LANES     = OUT_WIDTH / IN_WIDTH;
  localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LANE_LSB  = $clog2(IN_BYTES);
  localparam int IDX_W     = $clog2(NUM_PORTS);
  localparam int LAST      = RAM_LATENCY - 1;

  genvar gi;

  // -------------------------------------------------------------------------
  // Per-port views of the packed request fields
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
  logic [IN_BYTES-1:0]   be_arr    [NUM_PORTS];
  logic [IN_WIDTH-1:0]   wdata_arr [NUM_PORTS];
  logic [LANE_W-1:0]     lane_arr  [NUM_PORTS];

  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.port_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign be_arr[gi]    = bus.port_be_i[gi*IN_BYTES +: IN_BYTES];
    assign wdata_arr[gi] = bus.port_wdata_i[gi*IN_WIDTH +: IN_WIDTH];
    if (LANES > 1) begin : g_lane
      // Lane = which IN_WIDTH slice of the RAM word the byte address hits.
      assign lane_arr[gi] = addr_arr[gi][LANE_LSB +: LANE_W];
    end else begin : g_nolane
      assign lane_arr[gi] = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] rr_ptr_next;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             found;
  logic [IDX_W-1:0] cand;
  int               cand_int;

  assign any_req = |bus.port_req_i;

  always_comb begin
    winner   = '0;
    found    = 1'b0;
    cand     = '0;
    cand_int = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ARB_MODE == 0) begin
        cand_int = i;
      end else begin
        // Rotate the search so it starts at rr_ptr and wraps at NUM_PORTS
        // (NUM_PORTS need not be a power of two).
        cand_int = int'(rr_ptr_reg) + i;
        if (cand_int >= NUM_PORTS) begin
          cand_int = cand_int - NUM_PORTS;
        end
      end
      cand = IDX_W'(cand_int);
      if (!found && bus.port_req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    bus.port_gnt_o = '0;
    if (any_req) begin
      bus.port_gnt_o[winner] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (any_req) begin
      if (winner == IDX_W'(NUM_PORTS - 1)) begin
        rr_ptr_next = '0;
      end else begin
        rr_ptr_next = winner + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // -------------------------------------------------------------------------
  // RAM command: winner's fields, lane-steered
  // -------------------------------------------------------------------------
  logic [IN_BYTES-1:0] win_be;
  logic [IN_WIDTH-1:0] win_wdata;
  logic [LANE_W-1:0]   win_lane;

  assign win_be    = be_arr[winner];
  assign win_wdata = wdata_arr[winner];
  assign win_lane  = lane_arr[winner];

  assign bus.ram_en_o    = any_req;
  assign bus.ram_addr_o  = addr_arr[winner];
  assign bus.ram_we_o    = bus.port_we_i[winner];
  assign bus.ram_be_o    = OUT_BYTES'(win_be) << (int'(win_lane) * IN_BYTES);
  // Replicating the data means the RAM only needs the byte enables to pick
  // the lane; no data shifter required.
  assign bus.ram_wdata_o = {LANES{win_wdata}};

  // -------------------------------------------------------------------------
  // Response pipeline
  // -------------------------------------------------------------------------
  // Valid and port index travel the full depth. The lane is only ever needed
  // at stage 0: with latency 1 stage 0 is the responding stage, with latency
  // 2 the read data is captured out of stage 0 into the output register.
  logic             stage_valid_reg [RAM_LATENCY];
  logic [IDX_W-1:0] stage_idx_reg   [RAM_LATENCY];
  logic [LANE_W-1:0] stage0_lane_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RAM_LATENCY; s++) begin
        stage_valid_reg[s] <= 1'b0;
        stage_idx_reg[s]   <= '0;
      end
      stage0_lane_reg <= '0;
    end else begin
      stage_valid_reg[0] <= any_req;
      stage_idx_reg[0]   <= winner;
      stage0_lane_reg    <= win_lane;
      for (int s = 1; s < RAM_LATENCY; s++) begin
        stage_valid_reg[s] <= stage_valid_reg[s-1];
        stage_idx_reg[s]   <= stage_idx_reg[s-1];
      end
    end
  end

  logic             rsp_valid;
  logic [IDX_W-1:0] rsp_idx;
  logic [IN_WIDTH-1:0] lane_data;

  assign rsp_valid = stage_valid_reg[LAST];
  assign rsp_idx   = stage_idx_reg[LAST];
  assign lane_data = bus.ram_rdata_i[stage0_lane_reg*IN_WIDTH +: IN_WIDTH];

  always_comb begin
    bus.port_rvalid_o = '0;
    if (rsp_valid) begin
      bus.port_rvalid_o[rsp_idx] = 1'b1;
    end
  end

  if (RAM_LATENCY == 1) begin : g_lat1
    // Responding port sees the RAM lane directly; every port keeps a copy of
    // its last response so it holds while other ports are being served.
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [IN_WIDTH-1:0] hold_reg;
      logic                hit;

      assign hit = rsp_valid && (rsp_idx == IDX_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_reg <= '0;
        end else if (hit) begin
          hold_reg <= lane_data;
        end
      end

      assign bus.port_rdata_o[gi*IN_WIDTH +: IN_WIDTH] = hit ? lane_data : hold_reg;
    end
  end else begin : g_lat2
    // Extra timing stage: the RAM word present while the request sits in
    // stage 0 is registered, so it leaves the block together with rvalid one
    // cycle later with no combinational path from ram_rdata_i.
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [IN_WIDTH-1:0] rdata_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_reg <= '0;
        end else if (stage_valid_reg[0] && (stage_idx_reg[0] == IDX_W'(gi))) begin
          rdata_reg <= lane_data;
        end
      end

      assign bus.port_rdata_o[gi*IN_WIDTH +: IN_WIDTH] = rdata_reg;
    end
  end

endmodule
